seq_mag_comp: RTL and testbench
===============================

SEQ_MAG_COMP -- requirements
Module: seq_mag_comp

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits.
REQ-002 SHALL have parameter DIGIT, default 4, bits compared per cycle; WIDTH SHALL be an integer multiple of DIGIT; NDIG = WIDTH/DIGIT.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  request a comparison; accepted only when ready=1.
REQ-006 signed_mode  input  1  0 = unsigned compare, 1 = two's-complement compare; sampled with start.
REQ-007 a  input  WIDTH  operand A; sampled with start.
REQ-008 b  input  WIDTH  operand B; sampled with start.
REQ-009 ready  output  1  high in IDLE only.
REQ-010 done  output  1  one-cycle pulse when a result is written.
REQ-011 equal  output  1  registered result, A == B.
REQ-012 greater  output  1  registered result, A > B.
REQ-013 lower  output  1  registered result, A < B.

Function
REQ-014 SHALL implement FSM with states IDLE, CMP and DONE.
REQ-015 IDLE: start=1 at an edge SHALL latch a, b and signed_mode, clear equal/greater/lower, load digit index NDIG-1, and go to CMP.
REQ-016 CMP: each edge SHALL compare one DIGIT-bit slice, most significant slice first, then decrement the index.
REQ-017 With signed_mode=1, the MSB of both latched operands SHALL be inverted before comparison (offset-binary), and all other bits SHALL be compared unsigned.
REQ-018 A slice with A>B SHALL set greater; A<B SHALL set lower; equal slices SHALL continue to the next slice.
REQ-019 If all NDIG slices are equal, equal SHALL be set at the edge that evaluates slice 0.
REQ-020 The edge that writes a result SHALL move the FSM to DONE; done SHALL be 1 for exactly that one DONE cycle; DONE SHALL then go to IDLE unconditionally.
REQ-021 After a result is written, equal/greater/lower SHALL be one-hot and SHALL hold until the next accepted start or reset.
REQ-022 start while ready=0 SHALL be ignored, with no queuing; a, b and signed_mode changes during CMP SHALL have no effect.
REQ-023 The first accepted start SHALL occur no earlier than the cycle after done, because ready=0 in DONE.
REQ-024 NDIG=1 (DIGIT=WIDTH) SHALL be legal: result is written at the first CMP edge.

Reset
REQ-025 rst=1 at an edge SHALL force IDLE and set ready=1, done=0, equal=0, greater=0, lower=0; rst SHALL take priority over start.
REQ-026 rst asserted during CMP or DONE SHALL abort the operation with no done pulse; the internal operand registers MAY retain stale values.

Configuration
REQ-027 Macro COMP_EARLY_EXIT_EN defined: the result SHALL be written at the first differing slice, so latency is variable, 1..NDIG CMP cycles.
REQ-028 Macro COMP_EARLY_EXIT_EN undefined: CMP SHALL always run all NDIG cycles, recording the first differing slice's verdict, and the result SHALL be written at slice 0, giving fixed latency.
REQ-029 Both builds SHALL give identical result values for identical inputs.

Verification (WIDTH=16, DIGIT=4, start accepted at edge T0)
REQ-030 a=0x1234, b=0x1234, signed_mode=0 -> done=1 after edge T4, equal=1, greater=0, lower=0, in both builds.
REQ-031 a=0x8000, b=0x7FFF -> signed_mode=0 gives greater=1; signed_mode=1 gives lower=1.
REQ-032 a=0xA000, b=0x1000, unsigned -> greater=1; done after edge T1 with COMP_EARLY_EXIT_EN, after edge T4 without it.
REQ-033 Second start pulsed during CMP with different operands -> ignored; the first result is reported; ready returns to 1 one cycle after done.
REQ-034 rst pulsed at edge T2 of an operation -> no done pulse, all outputs 0, ready=1; a new start at T3 completes normally.

Source files
------------

// File: rtl/seq_mag_comp.sv
// seq_mag_comp: sequential magnitude comparator working DIGIT bits per cycle,
// most significant slice first, with optional two's-complement ordering.
// Optional feature macro: COMP_EARLY_EXIT_EN
//   defined   -> result is written at the first differing slice (1..NDIG cycles)
//   undefined -> every comparison runs all NDIG slices (fixed latency)
// Both builds produce identical equal/greater/lower values for the same inputs.
module seq_mag_comp #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic             equal,
    output logic             greater,
    output logic             lower
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NDIG - 1);

    typedef enum logic [1:0] {
        IDLE,
        CMP,
        DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_opA;
    logic [WIDTH-1:0] r_opB;
    logic [IDXW-1:0]  r_idx;

    logic [WIDTH-1:0] w_signMask;
    logic [DIGIT-1:0] w_sliceA;
    logic [DIGIT-1:0] w_sliceB;
    logic             w_sliceGt;
    logic             w_sliceLt;
    logic             w_lastSlice;

`ifndef COMP_EARLY_EXIT_EN
    logic             r_decided;
    logic             r_decidedGt;
`endif

    // Flipping the MSB of both operands maps two's-complement order onto
    // unsigned order, so the slice datapath never needs to know the mode.
    assign w_signMask = {signed_mode, {(WIDTH-1){1'b0}}};

    // The operands are shifted left after every slice, so the slice under
    // evaluation is always the top DIGIT bits of the working registers.
    assign w_sliceA    = r_opA[WIDTH-1 -: DIGIT];
    assign w_sliceB    = r_opB[WIDTH-1 -: DIGIT];
    assign w_sliceGt   = (w_sliceA > w_sliceB);
    assign w_sliceLt   = (w_sliceA < w_sliceB);
    assign w_lastSlice = (r_idx == '0);

    // Control FSM with registered ready/done/result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_opA   <= '0;
            r_opB   <= '0;
            r_idx   <= '0;
            ready   <= 1'b1;
            done    <= 1'b0;
            equal   <= 1'b0;
            greater <= 1'b0;
            lower   <= 1'b0;
`ifndef COMP_EARLY_EXIT_EN
            r_decided   <= 1'b0;
            r_decidedGt <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_opA   <= a ^ w_signMask;
                        r_opB   <= b ^ w_signMask;
                        r_idx   <= LAST_IDX;
                        equal   <= 1'b0;
                        greater <= 1'b0;
                        lower   <= 1'b0;
                        ready   <= 1'b0;
`ifndef COMP_EARLY_EXIT_EN
                        r_decided   <= 1'b0;
                        r_decidedGt <= 1'b0;
`endif
                        r_state <= CMP;
                    end else begin
                        ready <= 1'b1;
                    end
                end

                CMP: begin
                    r_opA <= r_opA << DIGIT;
                    r_opB <= r_opB << DIGIT;
                    r_idx <= r_idx - IDXW'(1);
`ifdef COMP_EARLY_EXIT_EN
                    if (w_sliceGt || w_sliceLt) begin
                        greater <= w_sliceGt;
                        lower   <= w_sliceLt;
                        done    <= 1'b1;
                        r_state <= DONE;
                    end else if (w_lastSlice) begin
                        equal   <= 1'b1;
                        done    <= 1'b1;
                        r_state <= DONE;
                    end
`else
                    if (!r_decided && (w_sliceGt || w_sliceLt)) begin
                        r_decided   <= 1'b1;
                        r_decidedGt <= w_sliceGt;
                    end
                    if (w_lastSlice) begin
                        if (r_decided) begin
                            greater <= r_decidedGt;
                            lower   <= !r_decidedGt;
                        end else begin
                            greater <= w_sliceGt;
                            lower   <= w_sliceLt;
                            equal   <= !(w_sliceGt || w_sliceLt);
                        end
                        done    <= 1'b1;
                        r_state <= DONE;
                    end
`endif
                end

                DONE: begin
                    done    <= 1'b0;
                    ready   <= 1'b1;
                    r_state <= IDLE;
                end

                default: begin
                    done    <= 1'b0;
                    ready   <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mag_comp.sv
// tb_seq_mag_comp: directed and randomized checks of seq_mag_comp against a
// behavioural model (integer compare plus latency from the highest differing slice).
module tb_seq_mag_comp;

    localparam int WIDTH = 16;
    localparam int DIGIT = 4;
    localparam int NDIG  = WIDTH / DIGIT;

    logic             clk;
    logic             rst;
    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             done;
    logic             equal;
    logic             greater;
    logic             lower;

    int vectorCount;
    int missCount;

    seq_mag_comp #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .signed_mode(signed_mode),
        .a(a),
        .b(b),
        .ready(ready),
        .done(done),
        .equal(equal),
        .greater(greater),
        .lower(lower)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Expected {equal, greater, lower} from plain integer comparison.
    function automatic logic [2:0] modelResult(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb, input logic sm);
        int ia;
        int ib;
        if (sm) begin
            ia = int'($signed(va));
            ib = int'($signed(vb));
        end else begin
            ia = int'({16'd0, va});
            ib = int'({16'd0, vb});
        end
        if (ia == ib) return 3'b100;
        if (ia > ib)  return 3'b010;
        return 3'b001;
    endfunction

    // Expected number of CMP edges before done is seen.
    function automatic int modelLatency(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb);
`ifdef COMP_EARLY_EXIT_EN
        int diff;
        diff = int'({16'd0, va ^ vb});
        for (int k = 1; k <= NDIG; k++) begin
            if ((diff >> (WIDTH - k * DIGIT)) != 0) return k;
        end
        return NDIG;
`else
        if (va == vb) return NDIG;
        return NDIG;
`endif
    endfunction

    // Launch one comparison and follow it to completion, optionally
    // disturbing the inputs and pulsing start while it is in progress.
    task automatic applyStimulus(input string tag, input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                                 input logic sm, input bit disturb);
        logic [2:0] expRes;
        int         expLat;
        int         cyc;
        bit         seen;
        expRes = modelResult(va, vb, sm);
        expLat = modelLatency(va, vb);
        checkOutput({tag, ".readyBefore"}, 32'(ready), 32'd1);
        a           = va;
        b           = vb;
        signed_mode = sm;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput({tag, ".readyBusy"}, 32'(ready), 32'd0);
        checkOutput({tag, ".cleared"}, 32'({equal, greater, lower}), 32'd0);
        cyc  = 0;
        seen = 0;
        while (!seen && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done) begin
                seen  = 1;
                start = 1'b0;
            end else if (disturb) begin
                a           = WIDTH'($urandom);
                b           = WIDTH'($urandom);
                signed_mode = 1'($urandom);
                start       = 1'b1;
                checkOutput({tag, ".readyCmp"}, 32'(ready), 32'd0);
            end
        end
        checkOutput({tag, ".doneSeen"}, 32'(seen), 32'd1);
        checkOutput({tag, ".latency"}, 32'(cyc), 32'(expLat));
        checkOutput({tag, ".result"}, 32'({equal, greater, lower}), 32'(expRes));
        checkOutput({tag, ".readyDone"}, 32'(ready), 32'd0);
        @(posedge clk);
        #1;
        checkOutput({tag, ".donePulse"}, 32'(done), 32'd0);
        checkOutput({tag, ".readyAfter"}, 32'(ready), 32'd1);
        checkOutput({tag, ".hold"}, 32'({equal, greater, lower}), 32'(expRes));
    endtask

    // Test sequence: reset, directed cases, mid-operation reset, random sweep.
    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        vectorCount = 0;
        missCount   = 0;
        rst         = 1'b1;
        start       = 1'b1;
        signed_mode = 1'b0;
        a           = '0;
        b           = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset.ready", 32'(ready), 32'd1);
        checkOutput("reset.done", 32'(done), 32'd0);
        checkOutput("reset.result", 32'({equal, greater, lower}), 32'd0);
        rst   = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("idle.ready", 32'(ready), 32'd1);

        applyStimulus("eq1234", 16'h1234, 16'h1234, 1'b0, 0);
        applyStimulus("u8000", 16'h8000, 16'h7FFF, 1'b0, 0);
        applyStimulus("s8000", 16'h8000, 16'h7FFF, 1'b1, 0);
        applyStimulus("uA000", 16'hA000, 16'h1000, 1'b0, 0);
        applyStimulus("sA000", 16'hA000, 16'h1000, 1'b1, 0);
        applyStimulus("lowSlice", 16'h5550, 16'h5551, 1'b0, 0);
        applyStimulus("sNegEq", 16'hFFFF, 16'hFFFF, 1'b1, 0);
        applyStimulus("ignore", 16'h0123, 16'h0122, 1'b0, 1);

        a           = 16'h4000;
        b           = 16'h0040;
        signed_mode = 1'b0;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("abort.noDoneT1", 32'(done), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("abort.ready", 32'(ready), 32'd1);
        checkOutput("abort.done", 32'(done), 32'd0);
        checkOutput("abort.result", 32'({equal, greater, lower}), 32'd0);
        applyStimulus("afterAbort", 16'h0040, 16'h4000, 1'b0, 0);

        for (int i = 0; i < 40; i++) begin
            ra = WIDTH'($urandom);
            case (i % 4)
                0:       rb = ra;
                1:       rb = ra ^ WIDTH'(1 << $urandom_range(WIDTH - 1, 0));
                default: rb = WIDTH'($urandom);
            endcase
            applyStimulus("rand", ra, rb, 1'($urandom), bit'(i % 3 == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
